// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests over a req/ack
// handshake and buffers returned words with their PCs for decode.
//
// state | meaning
// IDLE  | no request outstanding; requests fpc when the FIFO has room
// WAIT  | request outstanding; imem_req/imem_addr held until imem_ack
// KILL  | request outstanding but redirected; held until imem_ack, data dropped
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    state_t        state, state_nxt;
    logic          run;
    logic [31:0]   fpc;
    logic [31:0]   req_addr;
    logic [PW:0]   count;
    logic [PW-1:0] head, tail;
    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic          push, pop;
    logic          unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (imem_req && !imem_ack)
                    state_nxt = redirect ? KILL : WAIT;
            end
            WAIT: begin
                if (imem_ack)
                    state_nxt = IDLE;
                else if (redirect)
                    state_nxt = KILL;
            end
            KILL: begin
                if (imem_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // run holds off the first request until the first edge after reset release
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fpc;
        case (state)
            IDLE: begin
                imem_req  = run && (count < QFULL);
                imem_addr = fpc;
            end
            WAIT, KILL: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = fpc;
            end
        endcase
    end

    assign push = imem_ack && !redirect &&
                  ((state == IDLE && imem_req) || state == WAIT);
    assign pop  = id_valid && id_ready && !redirect;

    assign id_valid = (count != '0);
    assign id_inst  = id_valid ? q_inst[head] : 32'h0;
    assign id_pc    = id_valid ? q_pc[head]   : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run      <= 1'b0;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            run <= 1'b1;
            if (state == IDLE)
                req_addr <= fpc;
            if (redirect) begin
                fpc   <= {redirect_pc[31:2], 2'b00};
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) begin
                    fpc  <= fpc + 32'd4;
                    tail <= tail + 1'b1;
                end
                if (pop)
                    head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= imem_rdata;
            q_pc[tail]   <= fpc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: wait-state memory model returning addr ^ A5A5_0000,
// backpressure, redirects (idle and in-flight) and asynchronous reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int waits = 0;
    int wcnt;
    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc)
    );

    // memory: acks after 'waits' extra cycles, reset by the same reset
    assign imem_ack   = imem_req && (wcnt == waits);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk or posedge reset) begin
        if (reset)
            wcnt <= 0;
        else if (imem_req)
            wcnt <= imem_ack ? 0 : wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;

        // reset values, then zero-wait streaming
        cyc(1);
        chk("rst_req",   imem_req,  0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", id_valid,  0);
        chk("rst_inst",  id_inst,   32'h0);
        chk("rst_pc",    id_pc,     32'h0);
        reset = 1'b0;
        cyc(1);
        chk("t1_req",   imem_req,  1);
        chk("t1_addr",  imem_addr, 32'h0);
        chk("t1_valid", id_valid,  0);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t1_v",    id_valid, 1);
            chk("t1_pc",   id_pc,    32'(4*i));
            chk("t1_inst", id_inst,  32'(4*i) ^ 32'hA5A5_0000);
        end

        // three wait states
        reset = 1'b1; waits = 3; id_ready = 1'b1;
        cyc(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(1);
                chk("t2_req",   imem_req,  1);
                chk("t2_addr",  imem_addr, 32'(4*k));
                chk("t2_valid", id_valid,  (j == 0 && k > 0));
                if (j == 0 && k > 0)
                    chk("t2_pc", id_pc, 32'(4*(k-1)));
            end
        end
        cyc(1);
        chk("t2_pc_last", id_pc, 32'h8);

        // backpressure fills the FIFO and stops requests
        reset = 1'b1; waits = 0; id_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        for (int c = 3; c <= 10; c++) begin
            cyc(1);
            chk("t3_req_off", imem_req, 0);
            chk("t3_hold_pc", id_pc,    32'h0);
        end
        id_ready = 1'b1;
        cyc(1);
        chk("t3_pc4",   id_pc,   32'h4);
        chk("t3_inst4", id_inst, 32'hA5A5_0004);
        cyc(1);
        chk("t3_pc8",   id_pc,   32'h8);

        // redirect with the FIFO full
        reset = 1'b1; id_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("t4_full_v",   id_valid, 1);
        chk("t4_full_req", imem_req, 0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cyc(1);
        redirect = 1'b0; id_ready = 1'b1;
        chk("t4_flush_v", id_valid,  0);
        chk("t4_req",     imem_req,  1);
        chk("t4_addr",    imem_addr, 32'h100);
        cyc(1);
        chk("t4_v",    id_valid, 1);
        chk("t4_pc",   id_pc,    32'h100);
        chk("t4_inst", id_inst,  32'hA5A5_0100);

        // redirect while a 3-wait request to 0x10 is in flight
        reset = 1'b1; id_ready = 1'b0; waits = 0;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        waits = 3; redirect = 1'b1; redirect_pc = 32'h10;
        cyc(1);
        redirect = 1'b0; id_ready = 1'b1;
        chk("t5_req_a", imem_req,  1);
        chk("t5_addr_a", imem_addr, 32'h10);
        cyc(1);
        chk("t5_addr_b", imem_addr, 32'h10);
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc(1);
        redirect = 1'b0;
        chk("t5_kill_req",  imem_req,  1);
        chk("t5_kill_addr", imem_addr, 32'h10);
        cyc(1);
        chk("t5_kill_ack",  imem_ack,  1);
        chk("t5_kill_addr2", imem_addr, 32'h10);
        chk("t5_kill_v",    id_valid,  0);
        for (int c = 8; c <= 11; c++) begin
            cyc(1);
            chk("t5_addr_tgt", imem_addr, 32'h200);
            chk("t5_no_v",     id_valid,  0);
        end
        cyc(1);
        chk("t5_v",    id_valid, 1);
        chk("t5_pc",   id_pc,    32'h200);
        chk("t5_inst", id_inst,  32'hA5A5_0200);

        // asynchronous reset in the middle of WAIT
        reset = 1'b1; waits = 3; id_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("t6_pre_v",    id_valid,  1);
        chk("t6_pre_inst", id_inst,   32'hA5A5_0000);
        chk("t6_pre_addr", imem_addr, 32'h4);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_req",  imem_req,  0);
        chk("t6_v",    id_valid,  0);
        chk("t6_inst", id_inst,   32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0; id_ready = 1'b1;
        cyc(1);
        chk("t6_re_req",  imem_req,  1);
        chk("t6_re_addr", imem_addr, 32'h0);
        cyc(4);
        chk("t6_re_v",  id_valid, 1);
        chk("t6_re_pc", id_pc,    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RISC-V core. Owns the fetch PC, issues word requests to instruction memory over a req/ack handshake tolerant of wait states, and buffers returned words with their PCs in a small FIFO. Sits directly upstream of decode, where `inst_code` feeds the immediate generator and control. Handles redirects (taken branch/JAL) by flushing buffered and in-flight instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `QDEPTH`, default 2: FIFO entries; power of two, >= 2.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `redirect`  in  1  pipeline redirect; single-cycle pulse.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `id_ready`  in  1  decode accepts the head instruction this cycle.
- `id_valid`  out  1  head instruction valid.
- `id_inst`  out  32  head instruction word (`inst_code` to decode).
- `id_pc`  out  32  PC of head instruction.

## Operation
- State: fetch PC `fpc`, FIFO (count 0..QDEPTH, head/tail pointers wrapping mod QDEPTH), FSM {IDLE, WAIT, KILL}.
- IDLE: if FIFO count < QDEPTH, drive `imem_req`=1, `imem_addr`=`fpc`, move to WAIT. With ack in the same cycle (zero-wait), push and remain eligible to request next cycle.
- WAIT: hold `imem_req`=1 and `imem_addr` stable until `imem_ack`. On ack: push {`imem_rdata`, `fpc`}, `fpc`<=`fpc`+4 (wraps modulo 2^32), return to IDLE. Once raised, `imem_req` never drops before ack.
- At most one request outstanding. A request is issued only when count < QDEPTH, so a push never targets a full FIFO.
- Pop: when `id_valid` && `id_ready`, head advances. Push and pop may occur in the same cycle; count is unchanged.
- `id_valid` = (count != 0). When `id_valid`=0, `id_inst` and `id_pc` read 0.
- Redirect (highest priority): FIFO flushed (count<=0, pointers reset), any pop that cycle is ignored, `fpc`<=`{redirect_pc[31:2],2'b00}`.
  - If no request is in flight, or `imem_ack` arrives in the redirect cycle: discard that data and go to IDLE.
  - Otherwise go to KILL: keep `imem_req`=1 with the old address until ack, discard the data, then go to IDLE. No push occurs in KILL.
  - A redirect while in KILL only updates `fpc`; the state stays KILL.
- Reset mid-operation: all state returns to reset values immediately. An outstanding memory transaction is abandoned; the memory side is reset by the same `reset`.

## Timing
- Reset values (asynchronous): `fpc`=RESET_PC, FSM=IDLE, count=0, `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_inst`=0, `id_pc`=0. `imem_req` is forced to 0 while `reset`=1.
- First request: the first clock edge after `reset` falls begins the IDLE cycle with `imem_req`=1, `imem_addr`=RESET_PC.
- Fetch latency: request accepted with ack in cycle N -> `id_valid`=1 with that word in cycle N+1.
- Throughput: 1 instruction/cycle with zero-wait memory and `id_ready`=1. With k wait states, one instruction per k+1 cycles.
- Redirect in cycle N (no in-flight request) -> request to target in cycle N+1 -> first valid target instruction no earlier than N+2. `id_valid`=0 from cycle N+1 until then.
- `imem_addr` and `imem_req` are functions of registered state only; no combinational path from `imem_ack` or `id_ready`.

## Test plan
- Reset release, zero-wait memory returning `addr ^ 32'hA5A5_0000`, `id_ready`=1 -> `id_pc` sequence 0,4,8,12 on consecutive cycles starting 2 cycles after release; each `id_inst` matches.
- Memory with 3 wait states -> `imem_addr` stable across 4 cycles per request; one instruction per 4 cycles; no duplicated or skipped PCs.
- `id_ready`=0 for 10 cycles -> FIFO fills to QDEPTH (PCs 0,4), `imem_req` drops; on release, PCs 0,4,8 are delivered in order.
- Redirect to 32'h0000_0103 with the FIFO full -> `id_valid`=0 next cycle, next `imem_addr`=32'h0000_0100, first `id_pc`=0x100.
- Redirect to 0x200 during a 3-wait-state request to 0x10 -> `imem_req` held with addr 0x10 until ack, data discarded, next request to 0x200; no instruction with PC 0x10 appears.
- Assert `reset` mid-WAIT -> `imem_req`, `id_valid`, `id_inst` go to 0 immediately, without waiting for a clock edge; after release, fetch restarts at RESET_PC.
